// File: rtl/text_stream_writer.sv
// text_stream_writer: arbitrates characters from several producers, interprets
// control codes against a cursor, queues printable characters with their
// position and drains the queue into the display buffer write port.
module text_stream_writer #(
  parameter int NUM_SRC    = 3,
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int X_W        = 7,
  parameter int Y_W        = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          wrap_mode,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [8*NUM_SRC-1:0]          src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          write_enable,
  output logic [X_W-1:0]                write_x,
  output logic [Y_W-1:0]                write_y,
  output logic [6:0]                    write_data,
  input  logic                          busy,
  output logic [X_W-1:0]                cursor_x,
  output logic [Y_W-1:0]                cursor_y,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int EW = 7 + X_W + Y_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Arbitration
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic [7:0]       w_char;
  logic             w_accept;

  // Cursor
  logic [X_W-1:0]   r_cx;
  logic [Y_W-1:0]   r_cy;
  logic [X_W-1:0]   w_cx_nxt;
  logic [Y_W-1:0]   w_cy_nxt;
  logic [Y_W-1:0]   w_cy_adv;
  logic [X_W-1:0]   w_cx_dec;

  // FIFO
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic [EW-1:0]    w_push_ent;
  logic             w_pop;
  logic [EW-1:0]    w_head;

  // Drain
  state_t           r_state;
  state_t           w_state_nxt;
  logic [X_W-1:0]   r_wx;
  logic [Y_W-1:0]   r_wy;
  logic [6:0]       r_wd;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rptr];

  // Round-robin search: first valid source at or after the pointer.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_idx = PW'((32'(r_ptr) + k) % NUM_SRC);
      if (!w_any && src_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Grant only the winner, and only when the character can be taken.
  always_comb begin
    src_ready = '0;
    if (reset_n && !clear && !w_full && w_any) begin
      src_ready[w_win] = 1'b1;
    end
  end

  assign w_accept = |(src_ready & src_valid);

  // Select the winning source's character.
  always_comb begin
    w_char = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_win == PW'(i)) begin
        w_char = src_data[8*i +: 8];
      end
    end
  end

  // Row advance: wrap to the top or stick on the last row.
  always_comb begin
    w_cy_adv = r_cy;
    w_cx_dec = r_cx - X_W'(1);
    if (r_cy < Y_W'(ROWS - 1)) begin
      w_cy_adv = r_cy + Y_W'(1);
    end else if (!wrap_mode) begin
      w_cy_adv = '0;
    end
  end

  // Character interpretation: cursor update and FIFO push request.
  always_comb begin
    w_cx_nxt   = r_cx;
    w_cy_nxt   = r_cy;
    w_push     = 1'b0;
    w_push_ent = '0;
    if (clear) begin
      w_cx_nxt = '0;
      w_cy_nxt = '0;
    end else if (w_accept) begin
      if (w_char >= 8'h20 && w_char <= 8'h7E) begin
        w_push     = 1'b1;
        w_push_ent = {w_char[6:0], r_cx, r_cy};
        if (r_cx == X_W'(COLS - 1)) begin
          w_cx_nxt = '0;
          w_cy_nxt = w_cy_adv;
        end else begin
          w_cx_nxt = r_cx + X_W'(1);
        end
      end else begin
        case (w_char)
          8'h0D: w_cx_nxt = '0;
          8'h0A: w_cy_nxt = w_cy_adv;
          8'h08: begin
            if (r_cx != '0) begin
              w_cx_nxt   = w_cx_dec;
              w_push     = 1'b1;
              w_push_ent = {7'h20, w_cx_dec, r_cy};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Cursor and arbitration pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cx  <= '0;
      r_cy  <= '0;
      r_ptr <= '0;
    end else begin
      r_cx <= w_cx_nxt;
      r_cy <= w_cy_nxt;
      if (w_accept) begin
        r_ptr <= (w_win == PW'(NUM_SRC - 1)) ? '0 : w_win + PW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since the level gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_ent;
    end
  end

  // FIFO pointers and occupancy; clear flushes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM: pop when idle, strobe one cycle, then leave a dead cycle for busy.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!clear && !w_empty && !busy) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Capture the popped entry; outputs hold between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wx <= '0;
      r_wy <= '0;
      r_wd <= '0;
    end else if (w_pop) begin
      r_wd <= w_head[EW-1 -: 7];
      r_wx <= w_head[Y_W +: X_W];
      r_wy <= w_head[Y_W-1:0];
    end
  end

  // The strobe is the ISSUE state itself, so reset drops it asynchronously.
  assign write_enable = (r_state == ST_ISSUE);
  assign write_x      = r_wx;
  assign write_y      = r_wy;
  assign write_data   = r_wd;
  assign cursor_x     = r_cx;
  assign cursor_y     = r_cy;
  assign fifo_level   = r_level;

endmodule

// File: tb/tb_text_stream_writer.sv
// Bench for text_stream_writer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_text_stream_writer;

  localparam int NUM_SRC    = 3;
  localparam int COLS       = 80;
  localparam int ROWS       = 30;
  localparam int X_W        = 7;
  localparam int Y_W        = 5;
  localparam int FIFO_DEPTH = 16;

  logic                  clk;
  logic                  reset_n;
  logic                  clear;
  logic                  wrap_mode;
  logic [NUM_SRC-1:0]    src_valid;
  logic [8*NUM_SRC-1:0]  src_data;
  logic [NUM_SRC-1:0]    src_ready;
  logic                  write_enable;
  logic [X_W-1:0]        write_x;
  logic [Y_W-1:0]        write_y;
  logic [6:0]            write_data;
  logic                  busy;
  logic [X_W-1:0]        cursor_x;
  logic [Y_W-1:0]        cursor_y;
  logic [4:0]            fifo_level;

  text_stream_writer #(
    .NUM_SRC(NUM_SRC), .COLS(COLS), .ROWS(ROWS),
    .X_W(X_W), .Y_W(Y_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wrap_mode(wrap_mode),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .write_enable(write_enable), .write_x(write_x), .write_y(write_y),
    .write_data(write_data), .busy(busy), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  typedef struct {int d; int x; int y;} ent_t;
  ent_t mq[$];
  ent_t popped;
  int   m_cx, m_cy, m_ptr;
  int   cyc = 0;
  int   pop_cyc = -10;
  int   idle_from = 0;
  int   n_wr = 0;
  int   last_wx, last_wy, last_wd;
  int   acc_cyc, wr_cyc;
  int   acc_log[$];
  int   win, idx, exp_rdy;
  logic [7:0] m_ch;

  // Per-source pending characters
  logic [7:0]          srcq [NUM_SRC][$];
  logic [NUM_SRC-1:0]  drv_acc;
  bit                  rand_gap = 0;

  task automatic row_adv();
    if (m_cy < ROWS - 1) m_cy++;
    else if (!wrap_mode) m_cy = 0;
  endtask

  task automatic model_char(input logic [7:0] ch);
    ent_t e;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      e.d = int'(ch); e.x = m_cx; e.y = m_cy;
      mq.push_back(e);
      m_cx++;
      if (m_cx == COLS) begin
        m_cx = 0;
        row_adv();
      end
    end else if (ch == 8'h0D) begin
      m_cx = 0;
    end else if (ch == 8'h0A) begin
      row_adv();
    end else if (ch == 8'h08) begin
      if (m_cx > 0) begin
        m_cx--;
        e.d = 32; e.x = m_cx; e.y = m_cy;
        mq.push_back(e);
      end
    end
  endtask

  // Monitor and model, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      mq.delete();
      m_cx = 0; m_cy = 0; m_ptr = 0;
      pop_cyc = -10; idle_from = 0;
    end else begin
      chk("we", int'(write_enable), int'(pop_cyc == cyc - 1));
      if (write_enable) begin
        n_wr++;
        last_wx = int'(write_x); last_wy = int'(write_y); last_wd = int'(write_data);
        wr_cyc = cyc;
        if (pop_cyc == cyc - 1) begin
          chk("wr_data", last_wd, popped.d);
          chk("wr_x", last_wx, popped.x);
          chk("wr_y", last_wy, popped.y);
        end
      end
      chk("cur_x", int'(cursor_x), m_cx);
      chk("cur_y", int'(cursor_y), m_cy);
      chk("level", int'(fifo_level), mq.size());
      win = -1;
      if (!clear && mq.size() < FIFO_DEPTH) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          idx = (m_ptr + k) % NUM_SRC;
          if (win < 0 && src_valid[idx]) win = idx;
        end
      end
      exp_rdy = (win >= 0) ? (1 << win) : 0;
      chk("ready", int'(src_ready), exp_rdy);
      if (!clear && !busy && cyc >= idle_from && mq.size() > 0) begin
        popped = mq.pop_front();
        pop_cyc = cyc;
        idle_from = cyc + 3;
      end
      if (win >= 0) begin
        acc_cyc = cyc;
        acc_log.push_back(win);
        m_ch = src_data[8*win +: 8];
        model_char(m_ch);
        m_ptr = (win + 1) % NUM_SRC;
      end
      if (clear) begin
        mq.delete();
        m_cx = 0; m_cy = 0;
        if (idle_from > cyc + 1) idle_from = cyc + 1;
      end
    end
  end

  // Source driver: valid holds until accepted, then the next character follows.
  always begin
    logic [7:0] dump;
    @(negedge clk);
    drv_acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (drv_acc[i] && srcq[i].size() > 0) dump = srcq[i].pop_front();
      if (!(src_valid[i] && !drv_acc[i] && srcq[i].size() > 0))
        src_valid[i] = (srcq[i].size() > 0) && (!rand_gap || $urandom_range(0, 2) != 0);
      if (srcq[i].size() > 0) src_data[8*i +: 8] = srcq[i][0];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  function automatic bit drained();
    bit d;
    d = (src_valid == '0) && (mq.size() == 0) && (cyc > pop_cyc + 1);
    for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() > 0) d = 0;
    return d;
  endfunction

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && !drained()) begin
      tick(1);
      k++;
    end
    chk(tag, int'(drained()), 1);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    logic [31:0] u;
    r = $urandom_range(0, 15);
    u = $urandom;
    case (r)
      0: return 8'h0D;
      1: return 8'h0A;
      2: return 8'h08;
      3: return u[7:0];
      default: return 8'(8'h20 + $urandom_range(0, 94));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, p0, na;
    bit seen;
    reset_n = 1'b0; clear = 1'b0; wrap_mode = 1'b0; busy = 1'b0;
    src_valid = '1; src_data = {8'h33, 8'h32, 8'h31};
    #3;
    chk("rst_ready", int'(src_ready), 0);
    chk("rst_we", int'(write_enable), 0);
    chk("rst_cx", int'(cursor_x), 0);
    chk("rst_cy", int'(cursor_y), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_wxyd", int'({write_x, write_y, write_data}), 0);
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Single character latency
    srcq[0].push_back(8'h41);
    wait_drain("t1_drain", 50);
    chk("t1_latency", wr_cyc - acc_cyc, 2);
    chk("t1_wd", last_wd, 'h41);
    chk("t1_wx", last_wx, 0);
    chk("t1_wy", last_wy, 0);
    chk("t1_cx", int'(cursor_x), 1);
    chk("t1_cy", int'(cursor_y), 0);

    // Three sources competing
    pulse_clear();
    tick(1);
    acc_log.delete();
    p0 = m_ptr;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < NUM_SRC; i++) srcq[i].push_back(8'(8'h31 + i));
    wait_drain("t2_drain", 200);
    chk("t2_naccept", acc_log.size(), 12);
    for (int j = 0; j < acc_log.size() && j < 12; j++) chk("t2_order", acc_log[j], (p0 + j) % NUM_SRC);
    chk("t2_cx", int'(cursor_x), 12);

    // Last-cell write with both wrap modes
    for (int w = 0; w < 2; w++) begin
      wrap_mode = 1'(w);
      pulse_clear();
      for (int k = 0; k < ROWS - 1; k++) srcq[0].push_back(8'h0A);
      for (int k = 0; k < COLS - 1; k++) srcq[0].push_back(8'h78);
      srcq[0].push_back(8'h5A);
      wait_drain("t3_drain", 1500);
      chk("t3_wd", last_wd, 'h5A);
      chk("t3_wx", last_wx, COLS - 1);
      chk("t3_wy", last_wy, ROWS - 1);
      chk("t3_cx", int'(cursor_x), 0);
      chk("t3_cy", int'(cursor_y), (w == 0) ? 0 : ROWS - 1);
    end
    wrap_mode = 1'b0;

    // Backspace inside a row and at column 0
    pulse_clear();
    for (int k = 0; k < 3; k++) srcq[0].push_back(8'h0A);
    for (int k = 0; k < 5; k++) srcq[0].push_back(8'h62);
    srcq[0].push_back(8'h08);
    wait_drain("t4_drain", 200);
    chk("t4_wd", last_wd, 'h20);
    chk("t4_wx", last_wx, 4);
    chk("t4_wy", last_wy, 3);
    chk("t4_cx", int'(cursor_x), 4);
    chk("t4_cy", int'(cursor_y), 3);
    nw = n_wr;
    srcq[0].push_back(8'h0D);
    srcq[0].push_back(8'h08);
    wait_drain("t4b_drain", 50);
    chk("t4_bs0_writes", n_wr - nw, 0);
    chk("t4_bs0_cx", int'(cursor_x), 0);
    chk("t4_bs0_cy", int'(cursor_y), 3);

    // Back-pressure with a full FIFO
    pulse_clear();
    busy = 1'b1;
    for (int k = 0; k < 17; k++) srcq[0].push_back(8'(8'h41 + k));
    tick(40);
    chk("t5_level", int'(fifo_level), 16);
    chk("t5_ready", int'(src_ready), 0);
    chk("t5_valid", int'(src_valid[0]), 1);
    nw = n_wr;
    busy = 1'b0;
    wait_drain("t5_drain", 300);
    chk("t5_writes", n_wr - nw, 17);
    chk("t5_last", last_wd, 'h41 + 16);

    // clear beats a simultaneous offer
    pulse_clear();
    busy = 1'b1;
    for (int k = 0; k < 5; k++) srcq[1].push_back(8'h61);
    tick(15);
    chk("t6_level5", int'(fifo_level), 5);
    na = acc_log.size();
    clear = 1'b1;
    src_valid = 3'b001;
    src_data[7:0] = 8'h41;
    tick(1);
    clear = 1'b0;
    busy = 1'b0;
    nw = n_wr;
    tick(20);
    chk("t6_accepts", acc_log.size() - na, 0);
    chk("t6_writes", n_wr - nw, 0);
    chk("t6_level", int'(fifo_level), 0);
    chk("t6_cx", int'(cursor_x), 0);
    chk("t6_cy", int'(cursor_y), 0);

    // Randomized traffic
    rand_gap = 1;
    for (int it = 0; it < 1200; it++) begin
      busy = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) wrap_mode = ~wrap_mode;
      if ($urandom_range(0, 1) == 0) begin
        int s;
        s = $urandom_range(0, NUM_SRC - 1);
        if (srcq[s].size() < 4) srcq[s].push_back(rand_char());
      end
      tick(1);
    end
    clear = 1'b0;
    busy = 1'b0;
    rand_gap = 0;
    wait_drain("rnd_drain", 600);

    // Reset during a write strobe
    srcq[2].push_back(8'h51);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (write_enable) seen = 1;
    end
    chk("rst_mid_pre", int'(write_enable), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_we", int'(write_enable), 0);
    chk("rst_mid_level", int'(fifo_level), 0);
    chk("rst_mid_cx", int'(cursor_x), 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
